// File: rtl/rom_stream_reader.sv
// Burst reader: issues sequential ROM reads and streams the words out through a
// 2-entry FIFO with valid/ready backpressure, keeping a running checksum.
module rom_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              rom_me,
  output logic              rom_oe,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W:0]   issue_left, pop_left, eff_len;
  logic              inflight, rd_ptr, wr_ptr, pop;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic [DATA_W-1:0] fifo [2];

  assign eff_len   = (length > MAX_LEN) ? MAX_LEN : length;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? fifo[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (pop_left == ONE);
  // Slots committed after this cycle: buffered words plus the read in flight, less this pop.
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign rom_me    = (state == S_RUN) && (issue_left != '0) && (occ < 3'd2);
  assign rom_oe    = (state == S_RUN) || (state == S_FLUSH);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      issue_left  <= '0;
      pop_left    <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      rom_address <= '0;
      checksum    <= '0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      inflight <= rom_me;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        fifo[wr_ptr] <= rom_q;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        pop_left <= pop_left - ONE;
        checksum <= checksum + out_data;
      end
      if (rom_me) begin
        rom_address <= rom_address + ADDR_W'(1);
        issue_left  <= issue_left - ONE;
      end
      case (state)
        S_IDLE: if (start) begin
          rom_address <= base_addr;
          issue_left  <= eff_len;
          pop_left    <= eff_len;
          checksum    <= '0;
          state       <= (eff_len == '0) ? S_DONE : S_RUN;
        end
        S_RUN:   if (rom_me && issue_left == ONE) state <= S_FLUSH;
        S_FLUSH: if (pop && pop_left == ONE) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench: table of bursts replayed against a ROM whose word i is i+1,
// plus hand sequences for reset behaviour and mid-burst reset.
module tb_rom_stream_reader;
  logic        clock = 1'b0;
  logic        reset_n, start, busy, done, rom_me, rom_oe;
  logic        out_valid, out_ready, out_last;
  logic [10:0] base_addr, rom_address;
  logic [11:0] length;
  logic [31:0] rom_q, out_data, checksum;
  int          errors = 0;
  int          checks = 0;

  rom_stream_reader #(.ADDR_W(11), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .rom_me(rom_me), .rom_oe(rom_oe),
    .rom_address(rom_address), .rom_q(rom_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .checksum(checksum)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: word i holds i+1.
  always @(posedge clock) if (rom_me) rom_q <= {21'b0, rom_address} + 32'd1;

  typedef struct {
    logic [10:0] base;
    logic [11:0] len;
    int          mode;      // 0: ready=1, 1: ready 1,0,0 repeating, 2: ready from cycle 8
    int          exp_words;
    logic [31:0] exp_sum;
    int          exp_done;  // cycle of done after the accepting edge, -1 if not checked
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      1:       return (k % 3) == 1;
      2:       return k >= 8;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_burst(input vec_t v);
    int          k, issued, popped, first_me, first_vld, done_k;
    logic [31:0] sum, prev_data;
    logic        prev_stall;
    logic [10:0] a;
    issued = 0; popped = 0; first_me = -1; first_vld = -1; done_k = -1;
    sum = 0; prev_data = 0; prev_stall = 0;
    @(posedge clock); #1;
    start = 1; base_addr = v.base; length = v.len; out_ready = 1;
    @(posedge clock); #1;
    // inputs changed while busy must not matter
    base_addr = ~v.base; length = 12'd3;
    k = 1;
    while (k <= 5000) begin
      start     = (k == 2) || (k == v.exp_done);
      out_ready = rdy(v.mode, k);
      @(negedge clock);
      chk("busy", busy, 1);
      chk("rom_oe", rom_oe, !done);
      if (rom_me) begin
        if (first_me < 0) first_me = k;
        chk("issue_count", issued < v.exp_words, 1);
        a = v.base + issued[10:0];
        chk("rom_address", rom_address, a);
        chk("occupancy", (issued - popped + 1 - int'(out_valid && out_ready)) <= 2, 1);
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid) begin
        if (first_vld < 0) first_vld = k;
        chk("word_count", popped < v.exp_words, 1);
        a = v.base + popped[10:0];
        chk("out_data", out_data, {21'b0, a} + 32'd1);
        chk("out_last", out_last, popped == v.exp_words - 1);
        if (out_ready) begin
          sum = sum + out_data;
          popped++;
        end
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clock); #1;
      k++;
    end
    start = 0;
    if (done_k < 0) chk("done_timeout", 0, 1);
    if (v.exp_done >= 0) chk("done_cycle", done_k, v.exp_done);
    if (v.exp_words > 0) begin
      chk("first_rom_me", first_me, 1);
      chk("first_valid", first_vld, 3);
    end
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("done_width", done, 0);
    chk("words_total", popped, v.exp_words);
    chk("bench_sum", sum, v.exp_sum);
    chk("checksum", checksum, v.exp_sum);
    a = v.base + v.exp_words[10:0];
    chk("final_address", rom_address, a);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rom_me"}, rom_me, 0);
    chk({nm, "_rom_oe"}, rom_oe, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_rom_address"}, rom_address, 0);
    chk({nm, "_checksum"}, checksum, 0);
    chk({nm, "_out_data"}, out_data, 0);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t post;
    tbl[0] = '{11'd0,    12'd4,    0, 4,    32'd10,      7};
    tbl[1] = '{11'd2046, 12'd4,    0, 4,    32'd4098,    7};
    tbl[2] = '{11'd0,    12'd8,    1, 8,    32'd36,      -1};
    tbl[3] = '{11'd100,  12'd0,    0, 0,    32'd0,       1};
    tbl[4] = '{11'd5,    12'd1,    0, 1,    32'd6,       4};
    tbl[5] = '{11'd10,   12'd3,    2, 3,    32'd36,      -1};
    tbl[6] = '{11'd7,    12'd4095, 0, 2048, 32'd2098176, 2051};
    post   = '{11'd50,   12'd2,    0, 2,    32'd103,     5};

    reset_n = 0; start = 0; base_addr = 0; length = 0; out_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    @(posedge clock); #1;
    reset_n = 1;

    for (int i = 0; i < 7; i++) run_burst(tbl[i]);

    // Reset after the second word of a 16-word burst.
    @(posedge clock); #1;
    start = 1; base_addr = 0; length = 12'd16; out_ready = 1;
    @(posedge clock); #1;
    start = 0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    reset_n = 0;
    @(posedge clock); #1;
    reset_n = 1;
    @(negedge clock);
    chk_zero("abort");
    repeat (4) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
    end
    run_burst(post);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
